// File: rtl/ga_flow_ctrl.sv
// Top-level GA run sequencer: init-pop, then alternating fitness evaluation and breeding
// for the configured number of generations, with phase completion tracked by push counts.
module ga_flow_ctrl #(
  parameter int unsigned P_MAX   = 1024,
  parameter int unsigned G_MAX   = 1024,
  parameter int unsigned P_MAX_W = $clog2(P_MAX + 1),
  parameter int unsigned G_MAX_W = $clog2(G_MAX + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sw_rst,
  input  logic [P_MAX_W-1:0] cnfg_p,
  input  logic [G_MAX_W-1:0] cnfg_g,
  input  logic               start_pls,
  input  logic               init_push,
  input  logic               eval_done_pls,
  input  logic               breed_push,
  output logic               init_start_pls,
  output logic               eval_start_pls,
  output logic               breed_start_pls,
  output logic               busy,
  output logic [G_MAX_W-1:0] gen_cnt,
  output logic               done_pls,
  output logic               cfg_err_pls,
  output logic               proto_err
);

  typedef enum logic [2:0] {StIdle, StInit, StEval, StBreed, StDone} state_e;

  localparam logic [P_MAX_W-1:0] PMax = P_MAX_W'(P_MAX);
  localparam logic [G_MAX_W-1:0] GMax = G_MAX_W'(G_MAX);

  state_e               state_q, state_d;
  logic [P_MAX_W-1:0]   p_q, p_d, cnt_q, cnt_d;
  logic [G_MAX_W-1:0]   g_q, g_d, gen_q, gen_d;
  logic                 init_st_q, init_st_d, eval_st_q, eval_st_d, breed_st_q, breed_st_d;
  logic                 busy_q, busy_d, done_q, done_d, cerr_q, cerr_d, perr_q, perr_d;
  logic                 cfg_ok, pop_last, gen_last, stray;

  assign cfg_ok   = (cnfg_p != '0) && (cnfg_p <= PMax) && (cnfg_g != '0) && (cnfg_g <= GMax);
  assign pop_last = (cnt_q == p_q - P_MAX_W'(1));
  assign gen_last = (gen_q == g_q - G_MAX_W'(1));
  assign stray    = (init_push && state_q != StInit) || (breed_push && state_q != StBreed) ||
                    (eval_done_pls && state_q != StEval);

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    g_d        = g_q;
    cnt_d      = cnt_q;
    gen_d      = gen_q;
    perr_d     = perr_q;
    init_st_d  = 1'b0;
    eval_st_d  = 1'b0;
    breed_st_d = 1'b0;
    done_d     = 1'b0;
    cerr_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_pls) begin
          if (cfg_ok) begin
            p_d       = cnfg_p;
            g_d       = cnfg_g;
            cnt_d     = '0;
            gen_d     = '0;
            perr_d    = 1'b0;
            state_d   = StInit;
            init_st_d = 1'b1;
          end else begin
            cerr_d = 1'b1;
          end
        end
      end
      StInit: begin
        if (init_push) begin
          if (pop_last) begin
            cnt_d     = '0;
            state_d   = StEval;
            eval_st_d = 1'b1;
          end else begin
            cnt_d = cnt_q + P_MAX_W'(1);
          end
        end
      end
      StEval: begin
        if (eval_done_pls) begin
          if (gen_last) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d    = StBreed;
            breed_st_d = 1'b1;
          end
        end
      end
      StBreed: begin
        if (breed_push) begin
          if (pop_last) begin
            cnt_d     = '0;
            gen_d     = gen_q + G_MAX_W'(1);
            state_d   = StEval;
            eval_st_d = 1'b1;
          end else begin
            cnt_d = cnt_q + P_MAX_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A stray event in the same cycle as an accepted start still flags.
    if (stray) perr_d = 1'b1;
    busy_d = (state_d != StIdle);

    if (sw_rst) begin
      state_d    = StIdle;
      p_d        = '0;
      g_d        = '0;
      cnt_d      = '0;
      gen_d      = '0;
      perr_d     = 1'b0;
      busy_d     = 1'b0;
      init_st_d  = 1'b0;
      eval_st_d  = 1'b0;
      breed_st_d = 1'b0;
      done_d     = 1'b0;
      cerr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      p_q        <= '0;
      g_q        <= '0;
      cnt_q      <= '0;
      gen_q      <= '0;
      perr_q     <= 1'b0;
      busy_q     <= 1'b0;
      init_st_q  <= 1'b0;
      eval_st_q  <= 1'b0;
      breed_st_q <= 1'b0;
      done_q     <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      g_q        <= g_d;
      cnt_q      <= cnt_d;
      gen_q      <= gen_d;
      perr_q     <= perr_d;
      busy_q     <= busy_d;
      init_st_q  <= init_st_d;
      eval_st_q  <= eval_st_d;
      breed_st_q <= breed_st_d;
      done_q     <= done_d;
      cerr_q     <= cerr_d;
    end
  end

  assign init_start_pls  = init_st_q;
  assign eval_start_pls  = eval_st_q;
  assign breed_start_pls = breed_st_q;
  assign busy            = busy_q;
  assign gen_cnt         = gen_q;
  assign done_pls        = done_q;
  assign cfg_err_pls     = cerr_q;
  assign proto_err       = perr_q;

endmodule

// File: tb/tb_ga_flow_ctrl.sv
// Bench for ga_flow_ctrl: countdown-style reference model checked every cycle, plus
// directed scenarios with literal expectations at the key cycles.
module tb_ga_flow_ctrl;

  localparam int PW = 11;
  localparam int GW = 11;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sw_rst = 1'b0;
  logic [PW-1:0] cnfg_p = '0;
  logic [GW-1:0] cnfg_g = '0;
  logic          start_pls = 1'b0, init_push = 1'b0, eval_done_pls = 1'b0, breed_push = 1'b0;
  logic          init_start_pls, eval_start_pls, breed_start_pls, busy, done_pls;
  logic          cfg_err_pls, proto_err;
  logic [GW-1:0] gen_cnt;

  ga_flow_ctrl dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .cnfg_p(cnfg_p), .cnfg_g(cnfg_g),
    .start_pls(start_pls), .init_push(init_push), .eval_done_pls(eval_done_pls),
    .breed_push(breed_push), .init_start_pls(init_start_pls),
    .eval_start_pls(eval_start_pls), .breed_start_pls(breed_start_pls), .busy(busy),
    .gen_cnt(gen_cnt), .done_pls(done_pls), .cfg_err_pls(cfg_err_pls), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases as names, population progress as pushes still owed.
  localparam int IDLE = 0, INIT = 1, EVAL = 2, BREED = 3, DONE = 4;
  int m_phase, m_left, m_p, m_g, m_gen;
  bit m_is, m_es, m_bs, m_done, m_cerr, m_perr;

  task automatic m_clear();
    m_phase = IDLE; m_left = 0; m_p = 0; m_g = 0; m_gen = 0;
    m_is = 0; m_es = 0; m_bs = 0; m_done = 0; m_cerr = 0; m_perr = 0;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn || sw_rst) begin
      m_clear();
    end else begin
      bit stray;
      stray = (init_push && m_phase != INIT) || (breed_push && m_phase != BREED) ||
              (eval_done_pls && m_phase != EVAL);
      m_is = 0; m_es = 0; m_bs = 0; m_done = 0; m_cerr = 0;
      if (m_phase == DONE) begin
        m_phase = IDLE;
      end else if (m_phase == IDLE && start_pls) begin
        if (int'(cnfg_p) >= 1 && int'(cnfg_p) <= 1024 && int'(cnfg_g) >= 1 &&
            int'(cnfg_g) <= 1024) begin
          m_p = int'(cnfg_p); m_g = int'(cnfg_g); m_gen = 0; m_left = m_p;
          m_perr = 0; m_phase = INIT; m_is = 1;
        end else begin
          m_cerr = 1;
        end
      end else if ((m_phase == INIT && init_push) || (m_phase == BREED && breed_push)) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_phase == BREED) m_gen = m_gen + 1;
          m_left = m_p; m_phase = EVAL; m_es = 1;
        end
      end else if (m_phase == EVAL && eval_done_pls) begin
        if (m_gen + 1 == m_g) begin
          m_phase = DONE; m_done = 1;
        end else begin
          m_phase = BREED; m_bs = 1;
        end
      end
      if (stray) m_perr = 1;
    end
  end

  int n_eval = 0, n_breed = 0, n_init = 0, n_done = 0;
  int fail_prints = 0;

  always @(negedge clk) begin
    chk("init_start_pls", int'(init_start_pls), int'(m_is));
    chk("eval_start_pls", int'(eval_start_pls), int'(m_es));
    chk("breed_start_pls", int'(breed_start_pls), int'(m_bs));
    chk("busy", int'(busy), int'(m_phase != IDLE));
    chk("gen_cnt", int'(gen_cnt), m_gen);
    chk("done_pls", int'(done_pls), int'(m_done));
    chk("cfg_err_pls", int'(cfg_err_pls), int'(m_cerr));
    chk("proto_err", int'(proto_err), int'(m_perr));
    n_eval  += int'(eval_start_pls);
    n_breed += int'(breed_start_pls);
    n_init  += int'(init_start_pls);
    n_done  += int'(done_pls);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_cnt();
    n_eval = 0; n_breed = 0; n_init = 0; n_done = 0;
  endtask

  task automatic do_start(input int p, input int g);
    cnfg_p = PW'(p);
    cnfg_g = GW'(g);
    start_pls = 1'b1;
    cyc();
    start_pls = 1'b0;
  endtask

  task automatic pushes(input bit breed, input int n);
    if (breed) breed_push = 1'b1; else init_push = 1'b1;
    repeat (n) cyc();
    breed_push = 1'b0;
    init_push = 1'b0;
  endtask

  task automatic eval_done();
    eval_done_pls = 1'b1;
    cyc();
    eval_done_pls = 1'b0;
  endtask

  // Full legal run with literal checks at every phase boundary.
  task automatic run_full(input int p, input int g);
    do_start(p, g);
    chk("lit init_start", int'(init_start_pls), 1);
    chk("lit busy after start", int'(busy), 1);
    pushes(1'b0, p);
    for (int gi = 0; gi < g; gi++) begin
      chk("lit eval_start", int'(eval_start_pls), 1);
      chk("lit gen_cnt", int'(gen_cnt), gi);
      eval_done();
      if (gi < g - 1) begin
        chk("lit breed_start", int'(breed_start_pls), 1);
        pushes(1'b1, p);
      end else begin
        chk("lit done_pls", int'(done_pls), 1);
      end
    end
    cyc();
    chk("lit busy after done", int'(busy), 0);
    chk("lit final gen_cnt", int'(gen_cnt), g - 1);
  endtask

  initial begin
    cyc();
    chk("reset busy", int'(busy), 0);
    chk("reset gen_cnt", int'(gen_cnt), 0);
    chk("reset proto_err", int'(proto_err), 0);
    rstn = 1'b1;
    cyc();

    // Basic run p=16, g=3
    clr_cnt();
    run_full(16, 3);
    chk("basic eval_start count", n_eval, 3);
    chk("basic breed_start count", n_breed, 2);
    chk("basic done count", n_done, 1);

    // Minimum config
    clr_cnt();
    run_full(1, 1);
    chk("min breed_start count", n_breed, 0);

    // Illegal configs
    clr_cnt();
    do_start(0, 3);
    chk("p=0 cfg_err", int'(cfg_err_pls), 1);
    chk("p=0 busy", int'(busy), 0);
    cyc();
    chk("p=0 cfg_err one cycle", int'(cfg_err_pls), 0);
    do_start(5, 1025);
    chk("g=1025 cfg_err", int'(cfg_err_pls), 1);
    cyc();
    cyc();
    chk("illegal no init_start", n_init, 0);

    // Protocol error: breed_push during INIT
    do_start(4, 1);
    pushes(1'b1, 1);
    chk("proto_err set", int'(proto_err), 1);
    pushes(1'b0, 3);
    chk("3 pushes no eval_start", int'(eval_start_pls), 0);
    pushes(1'b0, 1);
    chk("4th push eval_start", int'(eval_start_pls), 1);
    eval_done();
    chk("proto run done", int'(done_pls), 1);
    cyc();
    chk("proto_err sticky", int'(proto_err), 1);

    // Accepted start clears proto_err; start_pls during EVAL ignored (p=8, g=2)
    clr_cnt();
    do_start(8, 2);
    chk("proto_err cleared", int'(proto_err), 0);
    pushes(1'b0, 8);
    cyc();
    start_pls = 1'b1;
    cyc();
    start_pls = 1'b0;
    chk("eval start ignored init", int'(init_start_pls), 0);
    chk("eval start ignored gen", int'(gen_cnt), 0);
    chk("eval start ignored busy", int'(busy), 1);
    eval_done();
    pushes(1'b1, 8);
    chk("ign gen_cnt=1", int'(gen_cnt), 1);
    eval_done();
    chk("ign done_pls", int'(done_pls), 1);
    chk("ign init_start count", n_init, 1);
    cyc();

    // sw_rst mid-BREED at gen_cnt=1
    clr_cnt();
    do_start(2, 3);
    pushes(1'b0, 2);
    eval_done();
    pushes(1'b1, 2);
    eval_done();
    chk("swr in breed gen", int'(gen_cnt), 1);
    pushes(1'b1, 1);
    sw_rst = 1'b1;
    eval_done_pls = 1'b1;
    cyc();
    sw_rst = 1'b0;
    eval_done_pls = 1'b0;
    chk("swr busy", int'(busy), 0);
    chk("swr gen_cnt", int'(gen_cnt), 0);
    chk("swr proto_err", int'(proto_err), 0);
    cyc();
    chk("swr no done", n_done, 0);
    clr_cnt();
    run_full(2, 2);
    chk("swr rerun done count", n_done, 1);

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
